// File: rtl/apb_ram_pkg.sv
// Shared types and elaboration-time helpers for the APB RAM completer.
// Width helpers stay valid for degenerate sizes such as one byte lane or DEPTH=1.
package apb_ram_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // A $clog2 that never returns 0, so it can size a vector.
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  // Number of paddr bits that select a byte within one word.
  function automatic int offset_bits(input int data_width);
    return (data_width <= 8) ? 0 : $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_ram_bytemem.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables and a registered read port.
// Contents are never reset; only the read register can be cleared.
module apb_ram_bytemem
  import apb_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6
) (
  input  logic                      clk,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [IDX_W-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      re,
  input  logic                      clr,
  input  logic [IDX_W-1:0]          raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  localparam int BYTES = bytes_of(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // clr wins over re so a bad read address returns zero instead of stale data.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/apb_ram_slave.sv
// APB4 completer in front of a byte-strobed RAM: FSM, wait counter, address decode
// and error response. Storage lives in apb_ram_bytemem.
module apb_ram_slave
  import apb_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int OFF_W = offset_bits(DATA_WIDTH);
  localparam int IDX_W = clog2_safe(DEPTH);

  apb_state_e            state;
  logic [3:0]            wait_cnt;
  logic                  err_q;
  logic                  write_q;
  logic [IDX_W-1:0]      idx_q;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  err_d;
  logic [IDX_W-1:0]      idx_d;
  logic                  setup;
  logic                  commit;
  logic [BYTES-1:0]      mem_be;
  logic                  mem_re;
  logic                  mem_clr;

  // Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen in IDLE,
  // then completes at the first edge of the access phase where psel, penable and pready
  // are all high; psel falling in ACCESS abandons it with no side effects.
  assign word_addr    = paddr >> OFF_W;
  assign misaligned   = (paddr & ADDR_WIDTH'(BYTES - 1)) != '0;
  assign out_of_range = 64'(word_addr) >= 64'(DEPTH);
  assign err_d        = misaligned | out_of_range;
  assign idx_d        = word_addr[IDX_W-1:0];

  assign setup   = (state == IDLE) && psel && !penable;
  assign pready  = (state == ACCESS) && (wait_cnt == 4'd0);
  assign pslverr = pready && err_q;
  assign commit  = (state == ACCESS) && psel && penable && pready
                   && write_q && !err_q && !preset;

  assign mem_be  = commit ? pstrb : '0;
  assign mem_re  = setup && !pwrite && !err_d && !preset;
  assign mem_clr = preset || (setup && !pwrite && err_d);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state    <= ACCESS;
            wait_cnt <= 4'(WAIT_STATES);
            err_q    <= err_d;
            write_q  <= pwrite;
            idx_q    <= idx_d;
          end
        end
        ACCESS: begin
          if (!psel || pready) begin
            state <= IDLE;
          end else if (penable && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  apb_ram_bytemem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (pclk),
    .be    (mem_be),
    .waddr (idx_q),
    .wdata (pwdata),
    .re    (mem_re),
    .clr   (mem_clr),
    .raddr (idx_d),
    .rdata (prdata)
  );

endmodule

// File: tb/tb_apb_ram_slave.sv
// Bench for apb_ram_slave: one instance with two wait states, one zero-wait, sharing the bus
// except for psel. A word-array model of the RAM predicts read data, errors and latency.
module tb_apb_ram_slave;

  logic        pclk;
  logic        preset;
  logic        psel_w, psel_z;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_w, prdata_z;
  logic        pready_w, pready_z;
  logic        pslverr_w, pslverr_z;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [2][16];
  int          ws_of [2] = '{2, 0};
  logic [31:0] rd;

  apb_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(2)) dut_w (
    .pclk(pclk), .preset(preset), .psel(psel_w), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_w), .pready(pready_w),
    .pslverr(pslverr_w)
  );

  apb_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut_z (
    .pclk(pclk), .preset(preset), .psel(psel_z), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_z), .pready(pready_z),
    .pslverr(pslverr_z)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input int which);
    return (which == 0) ? pready_w : pready_z;
  endfunction

  function automatic logic get_err(input int which);
    return (which == 0) ? pslverr_w : pslverr_z;
  endfunction

  function automatic logic [31:0] get_rd(input int which);
    return (which == 0) ? prdata_w : prdata_z;
  endfunction

  task automatic set_psel(input int which, input logic v);
    if (which == 0) psel_w = v;
    else            psel_z = v;
  endtask

  // driver: called at #1 after an edge; returns at #1 after the completion edge
  task automatic apb_xfer(input int which, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata);
    logic exp_err;
    int   waits;
    int   wi;
    exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd16);
    wi      = int'(addr >> 2) & 15;
    if (!wr) exp_q.push_back(exp_err ? 32'h0 : ref_mem[which][wi]);
    set_psel(which, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    while (!get_rdy(which) && waits < 40) begin
      check("slverr_while_waiting", 64'(get_err(which)), 64'd0);
      @(posedge pclk); #1;
      waits++;
    end
    check(wr ? "wr_wait_cycles" : "rd_wait_cycles", 64'(waits), 64'(ws_of[which]));
    check(wr ? "wr_pslverr" : "rd_pslverr", 64'(get_err(which)), 64'(exp_err));
    rdata = get_rd(which);
    if (!wr) check("rd_prdata", 64'(rdata), 64'(exp_q.pop_front()));
    @(posedge pclk); #1;
    set_psel(which, 1'b0);
    penable = 1'b0;
    if (wr && !exp_err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[which][wi][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  initial begin
    logic [31:0] addr;
    psel_w = 0; psel_z = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; pstrb = 0;
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    check("rst_pready_w", 64'(pready_w), 64'd0);
    check("rst_pslverr_w", 64'(pslverr_w), 64'd0);
    check("rst_prdata_w", 64'(prdata_w), 64'd0);
    check("rst_pready_z", 64'(pready_z), 64'd0);
    check("rst_prdata_z", 64'(prdata_z), 64'd0);

    // fill both RAMs so every model word is known
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        apb_xfer(d, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);

    // full write then read-back with two wait states
    apb_xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, rd);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd);
    check("deadbeef_rd", 64'(rd), 64'hDEADBEEF);

    // partial-lane write
    apb_xfer(0, 1'b1, 32'h04, 32'hAAAAAAAA, 4'hF, rd);
    apb_xfer(0, 1'b1, 32'h04, 32'h11223344, 4'h5, rd);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd);
    check("strb_merge_rd", 64'(rd), 64'hAA22AA44);

    // out-of-range read, misaligned write, then word 1 unchanged
    apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd);
    check("oob_rd_zero", 64'(rd), 64'h0);
    apb_xfer(0, 1'b1, 32'h06, 32'h99999999, 4'hF, rd);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd);
    check("after_err_rd", 64'(rd), 64'hAA22AA44);
    apb_xfer(0, 1'b1, 32'h0, 32'h12345678, 4'h0, rd);

    // zero-wait back-to-back
    for (int i = 0; i < 8; i++) apb_xfer(1, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);
    for (int i = 0; i < 8; i++) apb_xfer(1, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd);

    // reset during the second wait cycle of a write to 0x0C
    psel_w = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1 preset = 1;
    @(posedge pclk); #1 preset = 0; psel_w = 0; penable = 0;
    check("midrst_pready", 64'(pready_w), 64'd0);
    check("midrst_pslverr", 64'(pslverr_w), 64'd0);
    check("midrst_prdata", 64'(prdata_w), 64'd0);
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, rd);

    // psel dropped during a wait cycle
    psel_w = 1; penable = 0; pwrite = 1; paddr = 32'h10; pwdata = 32'hC0FFEE00; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1 psel_w = 0; penable = 0;
    @(posedge pclk); #1;
    check("drop_pready_w", 64'(pready_w), 64'd0);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);

    // psel dropped in the zero-wait completion cycle
    psel_z = 1; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'hBADC0DE0; pstrb = 4'hF;
    @(posedge pclk); #1 psel_z = 0; penable = 1;
    @(posedge pclk); #1 penable = 0;
    check("drop_pready_z", 64'(pready_z), 64'd0);
    apb_xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, rd);

    // penable with psel while idle is ignored
    psel_w = 1; penable = 1; pwrite = 1; paddr = 32'h18; pwdata = 32'h0BAD0BAD; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      check("idle_penable_pready", 64'(pready_w), 64'd0);
    end
    psel_w = 0; penable = 0;
    @(posedge pclk); #1;
    apb_xfer(0, 1'b0, 32'h18, 32'h0, 4'h0, rd);

    // randomized traffic on both instances
    for (int n = 0; n < 80; n++) begin
      int which;
      which = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) addr = $urandom_range(0, 32'h7F);
      else                           addr = 32'($urandom_range(0, 15) * 4);
      apb_xfer(which, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
